// File: rtl/counter_pkg.sv
// Shared definitions for the counter library: direction encoding and parameter helpers.
// Latency: n/a (package only).
// Backpressure: n/a.
package counter_pkg;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    // Bits needed to represent the values 0..n-1 (ceil(log2(n))), never less than 1.
    // Counter blocks compare this against their WIDTH to reject a MODULUS that does not fit.
    function automatic int cnt_clog2(input int n);
        int bits;
        bits = 0;
        while ((1 << bits) < n) begin
            bits++;
        end
        return (bits < 1) ? 1 : bits;
    endfunction

endpackage

// File: rtl/mod_n_next.sv
// Next value of a modulo-N up/down counter and range-end detection; purely combinational.
// Latency: 0 cycles.
// Backpressure: none; q/up -> q_next/hit every cycle.
//
// Ports:
//   q      current count (0..MODULUS-1)
//   up     direction, 1 = up, 0 = down
//   q_next value after one counting step (wrapped or saturated)
//   hit    q sits on the range end in the current direction
module mod_n_next
    import counter_pkg::*;
#(
    parameter int WIDTH    = 3,
    parameter int MODULUS  = 8,
    parameter int SATURATE = 0
) (
    input  logic [WIDTH-1:0] q,
    input  logic             up,
    output logic [WIDTH-1:0] q_next,
    output logic             hit
);

    // One guard bit so q+1 at MODULUS = 2**WIDTH cannot alias to a small value before the
    // range-end test has been applied.
    localparam logic [WIDTH:0] LAST = (WIDTH + 1)'(MODULUS - 1);
    localparam logic [WIDTH:0] ONE  = (WIDTH + 1)'(1);

    logic [WIDTH:0] q_ext;
    logic [WIDTH:0] sum;
    logic           sum_msb_unused;

    assign q_ext = {1'b0, q};

    always_comb begin
        sum = q_ext;
        hit = 1'b0;
        if (up == DIR_UP) begin
            if (q_ext == LAST) begin
                hit = 1'b1;
                sum = (SATURATE != 0) ? q_ext : '0;
            end else begin
                sum = q_ext + ONE;
            end
        end else begin
            if (q_ext == '0) begin
                hit = 1'b1;
                sum = (SATURATE != 0) ? q_ext : LAST;
            end else begin
                sum = q_ext - ONE;
            end
        end
    end

    // sum never exceeds LAST, so the guard bit is always zero here.
    assign q_next         = sum[WIDTH-1:0];
    assign sum_msb_unused = sum[WIDTH];

endmodule

// File: rtl/mod_n_updown_counter.sv
// Modulo-N up/down counter with clear, parallel load, wrap/saturate and cascade output.
// Latency: q, wrap, load_err update 1 cycle after the inputs; tc is combinational from en/up/q.
// Backpressure: none; en gates counting, cascade by driving the next stage's en from tc.
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   en, up       count enable, direction (1 = up)
//   clr          synchronous clear (highest priority)
//   load, d      synchronous parallel load; d >= MODULUS loads MODULUS-1 and flags load_err
//   q            registered count
//   tc           terminal count: en and q on the range end in the current direction
//   wrap         pulse: the previous cycle counted while on a range end
//   load_err     pulse: the previous cycle loaded an out-of-range d
module mod_n_updown_counter
    import counter_pkg::*;
#(
    parameter int WIDTH    = 3,
    parameter int MODULUS  = 8,
    parameter int SATURATE = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             up,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             wrap,
    output logic             load_err
);

    if (WIDTH < 1 || MODULUS < 2 || cnt_clog2(MODULUS) > WIDTH) begin : g_bad_params
        $error("mod_n_updown_counter: need WIDTH >= 1 and 2 <= MODULUS <= 2**WIDTH");
    end

    localparam logic [WIDTH-1:0] LAST    = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);

    logic [WIDTH-1:0] q_next;
    logic             hit;
    logic             d_over;

    mod_n_next #(
        .WIDTH    (WIDTH),
        .MODULUS  (MODULUS),
        .SATURATE (SATURATE)
    ) u_next (
        .q      (q),
        .up     (up),
        .q_next (q_next),
        .hit    (hit)
    );

    // hit depends only on q and up, so tc has no path from d, load or clr.
    assign tc = en & hit;

    // Widened compare: with MODULUS = 2**WIDTH no d is out of range.
    assign d_over = ({1'b0, d} >= MOD_EXT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q        <= '0;
            wrap     <= 1'b0;
            load_err <= 1'b0;
        end else if (clr) begin
            q        <= '0;
            wrap     <= 1'b0;
            load_err <= 1'b0;
        end else if (load) begin
            // Clamp keeps q inside 0..MODULUS-1 whatever is presented on d.
            q        <= d_over ? LAST : d;
            wrap     <= 1'b0;
            load_err <= d_over;
        end else if (en) begin
            q        <= q_next;
            wrap     <= hit;
            load_err <= 1'b0;
        end else begin
            wrap     <= 1'b0;
            load_err <= 1'b0;
        end
    end

endmodule
